// File: rtl/enreg_rr_arbiter.sv
// Round-robin arbiter sequencing N_REQ requesters onto one enabled storage register.
// Optional readback check: define ENREG_ARB_READBACK_EN to compare D_out in VERIFY.
module enreg_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic [WIDTH-1:0]       D_in,
  output logic                   en,
  input  logic [WIDTH-1:0]       D_out
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] win;
  logic             win_vld;
  logic [WIDTH-1:0] data, data_nxt;
  logic [WIDTH-1:0] d_in_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             en_nxt;
  logic [WIDTH-1:0] req_slice [N_REQ];

  // Per-requester view of the flat data bus
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign req_slice[i] = req_data[i*WIDTH +: WIDTH];
  end

  // First asserted request scanning upward from ptr with wraparound
  always_comb begin
    logic [IDX_W-1:0] cand;
    win     = ptr;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and next registered outputs
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    data_nxt  = data;
    d_in_nxt  = D_in;
    gnt_nxt   = '0;
    en_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt    = WRITE;
          idx_nxt      = win;
          data_nxt     = req_slice[win];
          d_in_nxt     = req_slice[win];
          gnt_nxt[win] = 1'b1;
          en_nxt       = 1'b1;
        end
      end
      WRITE: begin
        state_nxt = VERIFY;
      end
      VERIFY: begin
        state_nxt = IDLE;
        ptr_nxt   = (idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(idx + 1'b1);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      idx  <= '0;
      data <= '0;
      gnt  <= '0;
      en   <= 1'b0;
      D_in <= '0;
    end else begin
      ptr  <= ptr_nxt;
      idx  <= idx_nxt;
      data <= data_nxt;
      gnt  <= gnt_nxt;
      en   <= en_nxt;
      D_in <= d_in_nxt;
    end
  end

  // Completion pulse decoded from state so it lines up with the readback cycle
  always_comb begin
    done = '0;
    if (state == VERIFY) done[idx] = 1'b1;
  end

`ifdef ENREG_ARB_READBACK_EN
  assign err = (state == VERIFY) && (D_out != data);
`else
  logic unused_d_out;
  assign unused_d_out = ^D_out;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_enreg_rr_arbiter.sv
// Directed table-driven bench for enreg_rr_arbiter (N_REQ=4, WIDTH=1) with a register model on D_out.
module tb_enreg_rr_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 1;
`ifdef ENREG_ARB_READBACK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       req_data;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic             err;
  logic [0:0]       D_in;
  logic             en;
  logic [0:0]       D_out;
  logic [0:0]       reg_q = '0;
  logic             flip;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enreg_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .D_in(D_in), .en(en), .D_out(D_out)
  );

  // Shared storage register; flip corrupts the readback path
  always_ff @(posedge clk) if (en) reg_q <= D_in;
  assign D_out = flip ? ~reg_q : reg_q;

  typedef struct {
    bit       rst;
    bit [3:0] req;
    bit [3:0] data;
    bit       flip;
    bit [3:0] gnt;
    bit       en;
    bit       din;
    bit [3:0] done;
    bit       err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(bit r, bit [3:0] rq, bit [3:0] dt, bit fl,
                             bit [3:0] g, bit e, bit di, bit [3:0] dn, bit er);
    vec_t t;
    t.rst = r; t.req = rq; t.data = dt; t.flip = fl;
    t.gnt = g; t.en = e; t.din = di; t.done = dn; t.err = er;
    return t;
  endfunction

  task automatic check(string name, int row, logic [3:0] got, logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic wait_done(output logic [3:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) begin
        d  = done;
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [3:0] d;
    bit         ok;
    logic [3:0] order [4];

    rst = 1'b1; req = '0; req_data = '0; flip = 1'b0;

    // rst req data flip | gnt en din done err
    // reset then idle
    vq.push_back(v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vq.push_back(v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    // single request from requester 1, dropped during VERIFY
    vq.push_back(v(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 4'b0010, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 4'b0000, 0));
    // reset to ptr=0, then all four held: order 0,1,2,3,0
    vq.push_back(v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0001, 1, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 0, 4'b0001, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0010, 1, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 1, 4'b0010, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0100, 1, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 0, 4'b0100, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b1000, 1, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 1, 4'b1000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0000, 0, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b1111, 4'b1010, 0, 4'b0001, 1, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    // requester 3 then wrap to 0; mid-transaction data change ignored
    vq.push_back(v(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 1, 4'b1000, 0));
    vq.push_back(v(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    // reset during WRITE: aborted, no done, ptr back to 0
    vq.push_back(v(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 1, 4'b0000, 0));
    vq.push_back(v(1, 4'b0100, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b0011, 4'b0011, 0, 4'b0001, 1, 1, 4'b0000, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 4'b0001, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 4'b0000, 0));
    // corrupted readback: err only when the readback check is built in
    vq.push_back(v(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 0, 4'b0000, 0));
    vq.push_back(v(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0100, ERR_ON));
    vq.push_back(v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0));

    foreach (vq[i]) begin
      rst = vq[i].rst; req = vq[i].req; req_data = vq[i].data; flip = vq[i].flip;
      @(posedge clk); #1;
      check("gnt",  i, gnt,          vq[i].gnt);
      check("en",   i, {3'b0, en},   {3'b0, vq[i].en});
      check("D_in", i, {3'b0, D_in}, {3'b0, vq[i].din});
      check("done", i, done,         vq[i].done);
      check("err",  i, {3'b0, err},  {3'b0, vq[i].err});
    end

    // All held from ptr=3: service order 3,0,1,2 with correct readback
    order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b0010; order[3] = 4'b0100;
    req = 4'b1111; req_data = 4'b0101; flip = 1'b0;
    for (int t = 0; t < 4; t++) begin
      wait_done(d, ok);
      check("rr_timeout", 100 + t, {3'b0, ok}, 4'b0001);
      check("rr_done",    100 + t, d,          order[t]);
      check("rr_err",     100 + t, {3'b0, err}, 4'b0000);
      check("rr_dout",    100 + t, {3'b0, D_out}, {3'b0, |(order[t] & 4'b0101)});
    end
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("final_en", 200, {3'b0, en}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // en must coincide with a grant
  always @(negedge clk) begin
    if (!rst && (en !== (gnt != 4'b0))) begin
      n_bad++;
      $display("FAIL en_vs_gnt: en %b gnt %b", en, gnt);
    end
  end

endmodule
